// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one memory port between instruction fetch and
//                    load/store, with an LS priority and an IF starvation guard
// Revision 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [DW/8-1:0] ls_be,
    input  logic [AW-1:0]   ls_addr,
    input  logic [DW-1:0]   ls_wdata,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [DW-1:0]   ls_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] C_STARVE_MAX = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] starve_cnt;
    logic          owner_ls;
    logic          ls_wins;
    logic          if_wins;

    // Grants are decided combinationally so the requester sees them in the
    // same cycle it raises req; they can only fire in IDLE.
    always_comb begin
        ls_wins = 1'b0;
        if_wins = 1'b0;
        if (state == S_IDLE) begin
            if (ls_req && (!if_req || (starve_cnt < C_STARVE_MAX))) begin
                ls_wins = 1'b1;
            end else if (if_req) begin
                if_wins = 1'b1;
            end
        end
    end

    assign ls_gnt = ls_wins;
    assign if_gnt = if_wins;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
            owner_ls   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rvalid  <= 1'b0;
            ls_rvalid  <= 1'b0;
            if_rdata   <= '0;
            ls_rdata   <= '0;
        end else begin
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ls_wins) begin
                        state     <= S_REQ;
                        mem_req   <= 1'b1;
                        owner_ls  <= 1'b1;
                        mem_we    <= ls_we;
                        mem_be    <= ls_be;
                        mem_addr  <= ls_addr;
                        mem_wdata <= ls_wdata;
                        // Only LS wins that leave IF waiting count towards starvation.
                        if (!if_req) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt < C_STARVE_MAX) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else if (if_wins) begin
                        state      <= S_REQ;
                        mem_req    <= 1'b1;
                        owner_ls   <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_be     <= '1;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        starve_cnt <= '0;
                    end
                end
                S_REQ: begin
                    // A response coinciding with the grant is not ours yet.
                    if (mem_gnt) begin
                        state   <= S_WAIT;
                        mem_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        state <= S_IDLE;
                        if (owner_ls) begin
                            ls_rvalid <= 1'b1;
                            ls_rdata  <= mem_rdata;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_rdata;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : randomized requesters and memory, scoreboard checker
// Revision 1.0
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int STARVE_MAX = 4;
    localparam int N_CYCLES   = 4000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [3:0]    ls_be;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata, ls_rdata;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
        .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [69:0] got, input logic [69:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: one transaction in flight, tracked as request/response
    // bookkeeping plus a plain integer starvation count.
    logic [69:0] exp_mem[$];   // {owner_ls, we, be, addr, wdata}
    logic [32:0] exp_resp[$];  // {owner_ls, data}
    logic [68:0] m_last;
    logic [69:0] ent;
    logic [32:0] rsp;
    logic [31:0] m_if_rd, m_ls_rd;
    logic        m_busy, m_wait_gnt, m_pending, m_owner_ls, rv_due;
    logic        busy_now, e_ls, e_if;
    int          m_cnt;

    task automatic model_reset();
        exp_mem.delete();
        exp_resp.delete();
        m_last     = '0;
        m_if_rd    = '0;
        m_ls_rd    = '0;
        m_busy     = 1'b0;
        m_wait_gnt = 1'b0;
        m_pending  = 1'b0;
        m_owner_ls = 1'b0;
        rv_due     = 1'b0;
        m_cnt      = 0;
    endtask

    initial model_reset();

    always @(negedge clk) begin : monitor
        if (!rst_n) begin
            chk("reset_ctrl", 70'({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_req, mem_we, mem_be}), 70'(0));
            chk("reset_mem_fields", 70'({mem_addr, mem_wdata}), 70'(0));
            chk("reset_rdata", 70'({if_rdata, ls_rdata}), 70'(0));
            model_reset();
        end else begin
            // Response routing: one registered pulse, to the owner only.
            if (if_rvalid || ls_rvalid || rv_due) begin
                if (exp_resp.size() == 0) begin
                    chk("rvalid_unexpected", 70'({if_rvalid, ls_rvalid}), 70'(0));
                end else begin
                    rsp = exp_resp.pop_front();
                    if (rsp[32]) m_ls_rd = rsp[31:0];
                    else         m_if_rd = rsp[31:0];
                    chk("rvalid_route", 70'({if_rvalid, ls_rvalid}), 70'({!rsp[32], rsp[32]}));
                end
                rv_due = 1'b0;
            end
            chk("if_rdata", 70'(if_rdata), 70'(m_if_rd));
            chk("ls_rdata", 70'(ls_rdata), 70'(m_ls_rd));

            busy_now = m_busy;
            chk("mem_req", 70'(mem_req), 70'(m_wait_gnt));
            chk("mem_fields_stable", 70'({mem_we, mem_be, mem_addr, mem_wdata}), 70'(m_last));

            if (m_pending && mem_rvalid) begin
                exp_resp.push_back({m_owner_ls, mem_rdata});
                m_pending = 1'b0;
                m_busy    = 1'b0;
                rv_due    = 1'b1;
            end
            if (m_wait_gnt && mem_gnt && exp_mem.size() != 0) begin
                ent = exp_mem.pop_front();
                chk("mem_accept", 70'({mem_we, mem_be, mem_addr, mem_wdata}), 70'(ent[68:0]));
                m_owner_ls = ent[69];
                m_wait_gnt = 1'b0;
                m_pending  = 1'b1;
            end

            e_ls = !busy_now && ls_req && (!if_req || (m_cnt < STARVE_MAX));
            e_if = !busy_now && if_req && !e_ls;
            chk("gnt", 70'({if_gnt, ls_gnt}), 70'({e_if, e_ls}));
            if (e_ls) begin
                m_last = {ls_we, ls_be, ls_addr, ls_wdata};
                exp_mem.push_back({1'b1, m_last});
                m_cnt  = !if_req ? 0 : ((m_cnt < STARVE_MAX) ? m_cnt + 1 : STARVE_MAX);
            end else if (e_if) begin
                m_last = {1'b0, 4'hF, if_addr, 32'h0};
                exp_mem.push_back({1'b0, m_last});
                m_cnt  = 0;
            end
            if (e_ls || e_if) begin
                m_busy     = 1'b1;
                m_wait_gnt = 1'b1;
            end
        end
    end

    // Stimulus: requesters that hold req until granted, and a memory with
    // random stalls, random latency and stray responses it is allowed to send.
    logic seen_if_gnt, seen_ls_gnt, seen_acc, mem_out, did_rst;
    int   dly, stall;

    task automatic drive_idle();
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        mem_out = 1'b0; did_rst = 1'b0; dly = 0; stall = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(negedge clk);
            seen_if_gnt = if_gnt;
            seen_ls_gnt = ls_gnt;
            seen_acc    = mem_req && mem_gnt;
            @(posedge clk);
            #1;
            if (cyc >= 1500 && !did_rst && mem_out) begin
                // Abort in the middle of a transaction, then deliver its late response.
                did_rst = 1'b1;
                rst_n   = 1'b0;
                drive_idle();
                mem_out = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                rst_n      = 1'b1;
                mem_rvalid = 1'b1;
                mem_rdata  = $urandom;
                continue;
            end

            if (seen_if_gnt) if_req = 1'b0;
            if (!if_req && cyc < N_CYCLES - 40 && ($urandom % 4) != 0) begin
                if_req  = 1'b1;
                if_addr = $urandom;
            end
            if (seen_ls_gnt) ls_req = 1'b0;
            if (!ls_req && cyc < N_CYCLES - 40 && ($urandom % 8) != 0) begin
                ls_req   = 1'b1;
                ls_we    = $urandom % 2;
                ls_be    = 4'($urandom);
                ls_addr  = $urandom;
                ls_wdata = $urandom;
            end

            if (stall > 0) begin
                stall--;
                mem_gnt = 1'b0;
            end else if (($urandom % 16) == 0) begin
                stall   = 5;
                mem_gnt = 1'b0;
            end else begin
                mem_gnt = ($urandom % 3) != 0;
            end

            if (seen_acc) begin
                mem_out = 1'b1;
                dly     = $urandom_range(0, 3);
            end
            if (mem_out) begin
                if (dly == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = $urandom;
                    mem_out    = 1'b0;
                end else begin
                    dly--;
                    mem_rvalid = 1'b0;
                end
            end else begin
                mem_rvalid = ($urandom % 6) == 0;
                mem_rdata  = $urandom;
            end
        end
        chk("mid_reset_applied", 70'(did_rst), 70'(1));
        chk("drained_mem_req", 70'(mem_req), 70'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
